// File: rtl/gate_truth_checker.sv
// gate_truth_checker: board-side exerciser for a 3-input combinational gate.
// Sweeps {ch_a,ch_b,ch_c} through 0..7. Each vector is held for SETTLE_CYCLES
// cycles and then sampled for one cycle. The gate's response on led_d is
// compared with the EXPECTED truth table. The checker reports pass/fail, the
// mismatch count and the first failing vector index.
// Optional feature: define GATE_CHK_OBSERVE_EN to capture the raw led_d value
// for every vector on the observed output. When it is undefined, observed reads 0.
//
// Latency: a start accepted at edge 0 is registered once, so DRIVE begins at
// edge 1. Vector k therefore enters DRIVE at edge 1+k*(S+1) and enters SAMPLE
// at edge 1+k*(S+1)+S. done is high in the cycle after edge 8*(S+1)+1.
module gate_truth_checker #(
  parameter logic [7:0]  EXPECTED      = 8'h7F,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       ch_a,
  output logic       ch_b,
  output logic       ch_c,
  input  logic       led_d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_err_idx,
  output logic [7:0] observed
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, REPORT} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic       start_q;     // start captured while IDLE, consumed the next cycle
  logic [2:0] idx;
  logic [7:0] settle_cnt;
  logic       mismatch;
  logic [3:0] err_next;
  logic       accept;

  // led_d needs no synchroniser: the gate is combinational and its inputs are
  // driven from this clock domain, so led_d is already synchronous to clk.
  assign mismatch = (led_d != EXPECTED[idx]);
  assign err_next = err_count + {3'b000, mismatch};
  assign accept   = (state == IDLE) && start_q;

  // Next-state decode and Moore outputs.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a signal
    // unassigned and no latch is inferred.
    state_next          = state;
    busy                = 1'b0;
    done                = 1'b0;
    {ch_a, ch_b, ch_c}  = 3'b000;
    unique case (state)
      IDLE: begin
        if (start_q) state_next = DRIVE;
      end
      DRIVE: begin
        busy               = 1'b1;
        {ch_a, ch_b, ch_c} = idx;
        if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
      end
      SAMPLE: begin
        busy               = 1'b1;
        {ch_a, ch_b, ch_c} = idx;
        state_next         = (idx == 3'd7) ? REPORT : DRIVE;
      end
      REPORT: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, sweep position and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      idx           <= 3'd0;
      settle_cnt    <= 8'd0;
      err_count     <= 4'd0;
      first_err_idx <= 3'd0;
      pass          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every right-hand side reads the
      // pre-edge value. SAMPLE depends on this when it tests err_count for the
      // first mismatch and updates it in the same edge.
      state <= state_next;
      // start is honoured only when sampled in IDLE. The !start_q term keeps a
      // start held for two cycles from arming a second sweep.
      start_q <= (state == IDLE) && start && !start_q;
      unique case (state)
        IDLE: begin
          if (start_q) begin
            idx           <= 3'd0;
            settle_cnt    <= 8'd0;
            err_count     <= 4'd0;
            first_err_idx <= 3'd0;
            pass          <= 1'b0;
          end
        end
        DRIVE: settle_cnt <= settle_cnt + 8'd1;
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_next;
            if (err_count == 4'd0) first_err_idx <= idx;
          end
          // pass is updated on the last sample, so it is valid while done is high.
          if (idx == 3'd7) begin
            pass <= (err_next == 4'd0);
          end else begin
            idx        <= idx + 3'd1;
            settle_cnt <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_CHK_OBSERVE_EN
  logic [7:0] observed_q;

  // Raw led_d capture, one bit per vector; cleared when a sweep is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                observed_q      <= 8'h00;
    else if (accept)           observed_q      <= 8'h00;
    else if (state == SAMPLE)  observed_q[idx] <= led_d;
  end

  assign observed = observed_q;
`else
  assign observed = 8'h00;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker with default parameters (NAND3, S=4).
// The bench models the gate under test behaviourally: correct NAND3,
// stuck-at-1, or AND3. Expected results come from the truth tables and the
// timing formulas, worked out by hand.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ch_a, ch_b, ch_c;
  logic       led_d;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_err_idx;
  logic [7:0] observed;

  logic [1:0] gate_mode;   // 0 = NAND3, 1 = stuck-at-1, 2 = AND3
  int         checks = 0;
  int         errors = 0;

  gate_truth_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .ch_a          (ch_a),
    .ch_b          (ch_b),
    .ch_c          (ch_c),
    .led_d         (led_d),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .observed      (observed)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (gate_mode)
      2'd0:    led_d = ~(ch_a & ch_b & ch_c);
      2'd1:    led_d = 1'b1;
      default: led_d = ch_a & ch_b & ch_c;
    endcase
  end

  function automatic logic [7:0] exp_obs(input logic [7:0] captured);
`ifdef GATE_CHK_OBSERVE_EN
    return captured;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start so that it is sampled at edge 0, then watches edges 1..60.
  // A second start pulse is sampled at edge restart_at when restart_at is nonzero.
  task automatic run_sweep(input int restart_at, output int done_edge,
                           output int done_pulses, output bit seq_ok);
    logic [2:0] exp_ch;
    logic       exp_busy;
    done_edge   = -1;
    done_pulses = 0;
    seq_ok      = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start    = 1'b0;
      exp_busy = (n >= 1) && (n <= 40);
      exp_ch   = exp_busy ? 3'((n - 1) / 5) : 3'd0;
      if ({ch_a, ch_b, ch_c} !== exp_ch || busy !== exp_busy || done !== (n == 41))
        seq_ok = 1'b0;
      if (done === 1'b1) begin
        done_pulses++;
        if (done_edge < 0) done_edge = n;
      end
      if (n == restart_at - 1) start = 1'b1;
    end
  endtask

  initial begin
    int done_edge, done_pulses, rst_dones;
    bit seq_ok;
    rst_n     = 1'b0;
    start     = 1'b0;
    gate_mode = 2'd0;

    #1;
    check("rst_busy",     busy,          0);
    check("rst_done",     done,          0);
    check("rst_pass",     pass,          0);
    check("rst_err",      err_count,     0);
    check("rst_first",    first_err_idx, 0);
    check("rst_ch",       {ch_a, ch_b, ch_c}, 0);
    check("rst_observed", observed,      0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Correct NAND3.
    run_sweep(0, done_edge, done_pulses, seq_ok);
    check("nand_done_edge", done_edge,     41);
    check("nand_done_cnt",  done_pulses,   1);
    check("nand_seq",       seq_ok,        1);
    check("nand_pass",      pass,          1);
    check("nand_err",       err_count,     0);
    check("nand_first",     first_err_idx, 0);
    check("nand_observed",  observed,      exp_obs(8'h7F));

    // Stuck-at-1: only vector 7 (expected 0) fails.
    gate_mode = 2'd1;
    run_sweep(0, done_edge, done_pulses, seq_ok);
    check("stuck_done_edge", done_edge,     41);
    check("stuck_pass",      pass,          0);
    check("stuck_err",       err_count,     1);
    check("stuck_first",     first_err_idx, 7);
    check("stuck_observed",  observed,      exp_obs(8'hFF));

    // AND3: every vector is the inverse of NAND3.
    gate_mode = 2'd2;
    run_sweep(0, done_edge, done_pulses, seq_ok);
    check("and_pass",     pass,          0);
    check("and_err",      err_count,     8);
    check("and_first",    first_err_idx, 0);
    check("and_observed", observed,      exp_obs(8'h80));

    // start re-pulsed at edge 10 (mid-DRIVE) is ignored.
    gate_mode = 2'd0;
    run_sweep(10, done_edge, done_pulses, seq_ok);
    check("restart_done_edge", done_edge,   41);
    check("restart_done_cnt",  done_pulses, 1);
    check("restart_seq",       seq_ok,      1);
    check("restart_pass",      pass,        1);

    // start sampled at edge 42, while in REPORT, is ignored.
    run_sweep(42, done_edge, done_pulses, seq_ok);
    check("report_start_cnt", done_pulses, 1);
    check("report_start_seq", seq_ok,      1);

    // Reset at edge 20 of an AND3 sweep; by then three mismatches are recorded.
    gate_mode = 2'd2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_rst_err", err_count, 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",     busy,               0);
    check("mid_rst_ch",       {ch_a, ch_b, ch_c}, 0);
    check("mid_rst_done",     done,               0);
    check("mid_rst_err",      err_count,          0);
    check("mid_rst_first",    first_err_idx,      0);
    check("mid_rst_pass",     pass,               0);
    check("mid_rst_observed", observed,           0);
    rst_dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) rst_dones++;
    end
    check("mid_rst_no_done", rst_dones, 0);
    rst_n     = 1'b1;
    gate_mode = 2'd0;
    run_sweep(0, done_edge, done_pulses, seq_ok);
    check("post_rst_done_edge", done_edge, 41);
    check("post_rst_pass",      pass,      1);
    check("post_rst_err",       err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
